// File: rtl/serial_adder_ctrl_pkg.sv
// serial_adder_ctrl_pkg: shared FSM state encoding for the bit-serial adder controller
package serial_adder_ctrl_pkg;
  localparam int STATE_W = 2;
  typedef enum logic [STATE_W-1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/serial_adder_ctrl_if.sv
// serial_adder_ctrl_if: start/done request bus; SERIAL_ADDER_SUB_EN adds the sub request bit
interface serial_adder_ctrl_if #(parameter int WIDTH = 8);
  logic start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic C_in;
  logic busy;
  logic done;
  logic [WIDTH-1:0] S;
  logic C_out;
  logic overflow;
`ifdef SERIAL_ADDER_SUB_EN
  logic sub;
  modport master (output start, A, B, C_in, sub, input busy, done, S, C_out, overflow);
  modport slave (input start, A, B, C_in, sub, output busy, done, S, C_out, overflow);
`else
  modport master (output start, A, B, C_in, input busy, done, S, C_out, overflow);
  modport slave (input start, A, B, C_in, output busy, done, S, C_out, overflow);
`endif
endinterface

// File: rtl/serial_adder_ctrl_full_adder.sv
// serial_adder_ctrl_full_adder: purely combinational one-bit full-adder cell
module serial_adder_ctrl_full_adder (
  input  logic A,
  input  logic B,
  input  logic C_in,
  output logic S,
  output logic C_out
);
  assign S = A ^ B ^ C_in;
  assign C_out = (A & B) | (C_in & (A ^ B));
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder, one full-adder cell reused LSB first over WIDTH clocks.
// Define SERIAL_ADDER_SUB_EN to add the sub request bit (S = A - B).
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic reset_n,
  serial_adder_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  state_t state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, sum_sr, s_q, b_in;
  logic [CW-1:0] cnt;
  logic carry, c_q, ovf_q, cell_s, cell_c, c_init, accept, last;
`ifdef SERIAL_ADDER_SUB_EN
  assign b_in = bus.sub ? ~bus.B : bus.B;
  assign c_init = bus.sub | bus.C_in;
`else
  assign b_in = bus.B;
  assign c_init = bus.C_in;
`endif
  assign accept = bus.start && state != RUN;
  assign last = cnt == CW'(WIDTH - 1);
  serial_adder_ctrl_full_adder u_fa (
    .A(a_sr[0]),
    .B(b_sr[0]),
    .C_in(carry),
    .S(cell_s),
    .C_out(cell_c)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = (state == RUN) ? (last ? DONE : RUN) : (bus.start ? RUN : IDLE);
  always_comb begin
    bus.busy = state == RUN;
    bus.done = state == DONE;
    bus.S = s_q;
    bus.C_out = c_q;
    bus.overflow = ovf_q;
  end
  // carry FF holds the carry into the current bit, so on the last bit it is the carry into the MSB
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      a_sr <= '0;
      b_sr <= '0;
      sum_sr <= '0;
      s_q <= '0;
      cnt <= '0;
      carry <= 1'b0;
      c_q <= 1'b0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      a_sr <= bus.A;
      b_sr <= b_in;
      carry <= c_init;
      cnt <= '0;
    end else if (state == RUN) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      carry <= cell_c;
      cnt <= cnt + CW'(1);
      sum_sr <= {cell_s, sum_sr[WIDTH-1:1]};
      if (last) begin
        s_q <= {cell_s, sum_sr[WIDTH-1:1]};
        c_q <= cell_c;
        ovf_q <= carry ^ cell_c;
      end
    end
endmodule
